// File: rtl/power_noise_pkg.sv
// Shared types for the power-noise load sequencer: FSM state encoding and run modes.
package power_noise_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        ACT_ON    = 3'd2,
        ACT_OFF   = 3'd3,
        RAMP_DOWN = 3'd4
    } state_t;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/power_noise_status.sv
// Pass/fail aggregation for the load groups: sticky per-group fail, saturating
// failing-cycle counter and registered pass indication.
module power_noise_status #(
    parameter int NUM_GROUPS = 4,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                  dut_clk,
    input  logic                  reset_n,
    input  logic [NUM_GROUPS-1:0] grp_pass,
    input  logic [NUM_GROUPS-1:0] grp_fail,
    input  logic [NUM_GROUPS-1:0] grp_en,
    input  logic [NUM_GROUPS-1:0] mask,
    input  logic                  clear,
    input  logic                  act_on,
    output logic [NUM_GROUPS-1:0] fail_sticky,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic                  pass_out,
    output logic                  fail_out
);

    logic [NUM_GROUPS-1:0] hits;

    // A fail report from a group that is not currently enabled is noise, not a fault.
    assign hits     = grp_fail & grp_en;
    assign fail_out = |fail_sticky;

    always_ff @(posedge dut_clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_sticky <= '0;
            err_cnt     <= '0;
            pass_out    <= 1'b0;
        end else begin
            if (clear) begin
                fail_sticky <= '0;
                err_cnt     <= '0;
            end else begin
                fail_sticky <= fail_sticky | hits;
                if ((|hits) && (err_cnt != '1))
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
            pass_out <= act_on & ((grp_pass & mask) == mask) & ~fail_out;
        end
    end

endmodule

// File: rtl/power_noise_sequencer.sv
// Sequences load-group enables: staged ramp-up, continuous or burst activity,
// staged ramp-down, with status aggregation in power_noise_status.
module power_noise_sequencer
    import power_noise_pkg::*;
#(
    parameter int NUM_GROUPS    = 4,
    parameter int RAMP_STEP_CYC = 256,
    parameter int BURST_W       = 16,
    parameter int ERR_CNT_W     = 16
) (
    input  logic                  dut_clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode,
    input  logic [NUM_GROUPS-1:0] group_mask,
    input  logic [BURST_W-1:0]    on_cycles,
    input  logic [BURST_W-1:0]    off_cycles,
    input  logic [NUM_GROUPS-1:0] grp_pass,
    input  logic [NUM_GROUPS-1:0] grp_fail,
    output logic [NUM_GROUPS-1:0] grp_en,
    output logic                  busy,
    output logic                  pass_out,
    output logic                  fail_out,
    output logic [NUM_GROUPS-1:0] fail_sticky,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output state_t                state_dbg
);

    localparam int RAMP_W = $clog2(RAMP_STEP_CYC + 1);
    localparam int IDX_W  = $clog2(NUM_GROUPS + 1);
    localparam logic [RAMP_W-1:0] RAMP_RELOAD = RAMP_W'(RAMP_STEP_CYC - 1);

    // start/stop are single-cycle requests with no acknowledge: a request is taken
    // in the cycle it is high if the current state accepts it, otherwise dropped;
    // stop outranks start when both are high.

    state_t                state, state_nxt;
    logic                  cfg_mode;
    logic [NUM_GROUPS-1:0] cfg_mask;
    logic [BURST_W-1:0]    cfg_on, cfg_off, on_load;
    logic [RAMP_W-1:0]     ramp_cnt, ramp_cnt_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [BURST_W-1:0]    burst_cnt, burst_cnt_nxt;
    logic [NUM_GROUPS-1:0] grp_en_nxt;
    logic                  start_ok;

    function automatic logic [NUM_GROUPS-1:0] drop_highest(input logic [NUM_GROUPS-1:0] v);
        logic [NUM_GROUPS-1:0] r;
        logic                  found;
        r     = v;
        found = 1'b0;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                r[i]  = 1'b0;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    assign start_ok  = (state == IDLE) & start & ~stop;
    assign on_load   = (cfg_on == '0) ? '0 : cfg_on - BURST_W'(1);
    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Dwell counters hit zero on the last cycle of a dwell; the action happens on
    // the following edge, so a zero count also marks the start of a new dwell.
    always_comb begin
        state_nxt     = state;
        ramp_cnt_nxt  = ramp_cnt;
        idx_nxt       = idx;
        burst_cnt_nxt = burst_cnt;
        grp_en_nxt    = grp_en;
        unique case (state)
            IDLE: begin
                grp_en_nxt = '0;
                if (start_ok) begin
                    state_nxt    = RAMP_UP;
                    ramp_cnt_nxt = '0;
                    idx_nxt      = '0;
                end
            end
            RAMP_UP: begin
                if (stop) begin
                    state_nxt    = RAMP_DOWN;
                    ramp_cnt_nxt = '0;
                end else if (ramp_cnt != '0) begin
                    ramp_cnt_nxt = ramp_cnt - RAMP_W'(1);
                end else if (idx == IDX_W'(NUM_GROUPS)) begin
                    state_nxt     = ACT_ON;
                    grp_en_nxt    = cfg_mask;
                    burst_cnt_nxt = on_load;
                end else begin
                    grp_en_nxt   = grp_en | (cfg_mask & (NUM_GROUPS'(1) << idx));
                    idx_nxt      = idx + IDX_W'(1);
                    ramp_cnt_nxt = RAMP_RELOAD;
                end
            end
            ACT_ON: begin
                grp_en_nxt = cfg_mask;
                if (stop) begin
                    state_nxt    = RAMP_DOWN;
                    ramp_cnt_nxt = '0;
                end else if ((cfg_mode == MODE_BURST) && (burst_cnt == '0) && (cfg_off != '0)) begin
                    state_nxt     = ACT_OFF;
                    grp_en_nxt    = '0;
                    burst_cnt_nxt = cfg_off - BURST_W'(1);
                end else if (burst_cnt != '0) begin
                    burst_cnt_nxt = burst_cnt - BURST_W'(1);
                end
            end
            ACT_OFF: begin
                grp_en_nxt = '0;
                if (stop) begin
                    state_nxt = IDLE;
                end else if (burst_cnt == '0) begin
                    state_nxt     = ACT_ON;
                    grp_en_nxt    = cfg_mask;
                    burst_cnt_nxt = on_load;
                end else begin
                    burst_cnt_nxt = burst_cnt - BURST_W'(1);
                end
            end
            RAMP_DOWN: begin
                if (grp_en == '0) begin
                    state_nxt = IDLE;
                end else if (ramp_cnt == '0) begin
                    grp_en_nxt   = drop_highest(grp_en);
                    ramp_cnt_nxt = RAMP_RELOAD;
                end else begin
                    ramp_cnt_nxt = ramp_cnt - RAMP_W'(1);
                end
            end
            default: begin
                state_nxt  = IDLE;
                grp_en_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge dut_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            grp_en    <= '0;
            ramp_cnt  <= '0;
            idx       <= '0;
            burst_cnt <= '0;
            cfg_mode  <= 1'b0;
            cfg_mask  <= '0;
            cfg_on    <= '0;
            cfg_off   <= '0;
        end else begin
            state     <= state_nxt;
            grp_en    <= grp_en_nxt;
            ramp_cnt  <= ramp_cnt_nxt;
            idx       <= idx_nxt;
            burst_cnt <= burst_cnt_nxt;
            if (start_ok) begin
                cfg_mode <= mode;
                cfg_mask <= group_mask;
                cfg_on   <= on_cycles;
                cfg_off  <= off_cycles;
            end
        end
    end

    power_noise_status #(
        .NUM_GROUPS(NUM_GROUPS),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_status (
        .dut_clk    (dut_clk),
        .reset_n    (reset_n),
        .grp_pass   (grp_pass),
        .grp_fail   (grp_fail),
        .grp_en     (grp_en),
        .mask       (cfg_mask),
        .clear      (start_ok),
        .act_on     (state == ACT_ON),
        .fail_sticky(fail_sticky),
        .err_cnt    (err_cnt),
        .pass_out   (pass_out),
        .fail_out   (fail_out)
    );

endmodule

// File: tb/tb_power_noise_sequencer.sv
// Bench for power_noise_sequencer: timeline reference model feeding an expected
// queue, a negedge monitor comparing every cycle, plus directed spot checks.
module tb_power_noise_sequencer;
    import power_noise_pkg::*;

    localparam int N  = 4;
    localparam int R  = 8;
    localparam int BW = 16;
    localparam int EW = 4;
    localparam int W  = 18;

    logic          dut_clk    = 1'b0;
    logic          reset_n    = 1'b0;
    logic          start      = 1'b0;
    logic          stop       = 1'b0;
    logic          mode       = 1'b0;
    logic [N-1:0]  group_mask = '0;
    logic [BW-1:0] on_cycles  = '0;
    logic [BW-1:0] off_cycles = '0;
    logic [N-1:0]  grp_pass   = '0;
    logic [N-1:0]  grp_fail   = '0;
    logic [N-1:0]  grp_en;
    logic          busy;
    logic          pass_out;
    logic          fail_out;
    logic [N-1:0]  fail_sticky;
    logic [EW-1:0] err_cnt;
    state_t        state_dbg;

    power_noise_sequencer #(
        .NUM_GROUPS(N), .RAMP_STEP_CYC(R), .BURST_W(BW), .ERR_CNT_W(EW)
    ) dut (
        .dut_clk(dut_clk), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
        .group_mask(group_mask), .on_cycles(on_cycles), .off_cycles(off_cycles),
        .grp_pass(grp_pass), .grp_fail(grp_fail), .grp_en(grp_en), .busy(busy),
        .pass_out(pass_out), .fail_out(fail_out), .fail_sticky(fail_sticky),
        .err_cnt(err_cnt), .state_dbg(state_dbg)
    );

    always #5 dut_clk = ~dut_clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    // Reference model: run config, time since the start edge, stop time.
    bit           m_run   = 1'b0;
    int           m_t     = 0;
    int           m_stop  = -1;
    logic [N-1:0] m_mask  = '0;
    logic         m_mode  = 1'b0;
    int           m_on    = 0;
    int           m_off   = 0;
    bit           rand_io = 1'b0;
    state_t       e_state = IDLE;
    logic [N-1:0] e_en     = '0;
    logic [N-1:0] e_sticky = '0;
    logic [EW-1:0] e_err   = '0;
    logic         e_pass   = 1'b0;

    // Schedule without a stop: bit k enabled from 1+k*R, activity from 1+N*R.
    function automatic void base_at(input int t, output state_t s, output logic [N-1:0] en);
        int u, on_eff, p;
        en = '0;
        if (t <= N * R) begin
            s = RAMP_UP;
            for (int k = 0; k < N; k++)
                if (1 + k * R <= t) en[k] = m_mask[k];
        end else begin
            u      = t - (1 + N * R);
            on_eff = (m_on == 0) ? 1 : m_on;
            p      = on_eff + m_off;
            if (m_mode == MODE_CONT || m_off == 0 || (u % p) < on_eff) begin
                s  = ACT_ON;
                en = m_mask;
            end else begin
                s = ACT_OFF;
            end
        end
    endfunction

    function automatic void model_at(input int t, output state_t s, output logic [N-1:0] en);
        state_t       ps;
        logic [N-1:0] pe;
        int           c, idle_t, j, cleared;
        if (m_stop < 0 || t < m_stop) begin
            base_at(t, s, en);
        end else begin
            base_at(m_stop - 1, ps, pe);
            c      = $countones(pe);
            idle_t = (c == 0) ? m_stop + 1 : m_stop + 2 + (c - 1) * R;
            if (ps == ACT_OFF || t >= idle_t) begin
                s  = IDLE;
                en = '0;
            end else begin
                s = RAMP_DOWN;
                j = (t >= m_stop + 1) ? (t - m_stop - 1) / R + 1 : 0;
                if (j > c) j = c;
                en      = pe;
                cleared = 0;
                for (int i = N - 1; i >= 0; i--)
                    if (en[i] && cleared < j) begin
                        en[i]   = 1'b0;
                        cleared = cleared + 1;
                    end
            end
        end
    endfunction

    // Called right after each active edge with the inputs that edge sampled.
    task automatic model_edge();
        logic [N-1:0] hits;
        bit           accept;
        accept = !m_run && start && !stop;
        e_pass = (e_state == ACT_ON) && ((grp_pass & m_mask) == m_mask) && (e_sticky == '0);
        hits   = grp_fail & e_en;
        if (accept) begin
            e_sticky = '0;
            e_err    = '0;
        end else begin
            e_sticky = e_sticky | hits;
            if (hits != '0 && e_err != {EW{1'b1}}) e_err = e_err + 1'b1;
        end
        if (accept) begin
            m_run  = 1'b1;
            m_t    = 0;
            m_stop = -1;
            m_mask = group_mask;
            m_mode = mode;
            m_on   = int'(on_cycles);
            m_off  = int'(off_cycles);
        end else if (m_run) begin
            m_t = m_t + 1;
            if (stop && m_stop < 0 && e_state != RAMP_DOWN) m_stop = m_t;
        end
        if (m_run) begin
            model_at(m_t, e_state, e_en);
            if (e_state == IDLE) m_run = 1'b0;
        end else begin
            e_state = IDLE;
            e_en    = '0;
        end
        exp_q.push_back({e_state, e_state != IDLE, e_en, e_sticky, e_err, e_pass, e_sticky != '0});
    endtask

    always @(negedge dut_clk) begin
        logic [W-1:0] got, exp;
        if (exp_q.size() > 0) begin
            exp    = exp_q.pop_front();
            got    = {state_dbg, busy, grp_en, fail_sticky, err_cnt, pass_out, fail_out};
            checks = checks + 1;
            if (got !== exp) begin
                errors = errors + 1;
                $display("FAIL outputs_cmp @%0t got=%h exp=%h (state,busy,en,sticky,err,pass,fail)",
                         $time, got, exp);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic cycle();
        if (rand_io) begin
            grp_pass = ($urandom_range(0, 4) == 0) ? N'($urandom) : '1;
            grp_fail = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
        end
        @(posedge dut_clk);
        model_edge();
        #1;
    endtask

    task automatic start_run(input logic [N-1:0] msk, input logic md, input int on, input int off);
        group_mask = msk;
        mode       = md;
        on_cycles  = BW'(on);
        off_cycles = BW'(off);
        start      = 1'b1;
        cycle();
        start      = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic idle_wait();
        for (int i = 0; i < 200 && m_run; i++) cycle();
        chk("idle_timeout", int'(m_run), 0);
        cycle();
        chk("idle_busy", int'(busy), 0);
    endtask

    initial begin
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_en", int'(grp_en), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_sticky", int'(fail_sticky), 0);
        chk("rst_pass", int'(pass_out), 0);
        @(posedge dut_clk);
        #1 reset_n = 1'b1;
        cycle();

        // Continuous ramp, mask 1011.
        start_run(4'b1011, MODE_CONT, 0, 0);
        chk("busy_after_start", int'(busy), 1);
        for (int t = 1; t <= 40; t++) begin
            cycle();
            case (t)
                1:  chk("ramp_t1", int'(grp_en), 4'b0001);
                9:  chk("ramp_t9", int'(grp_en), 4'b0011);
                17: chk("ramp_t17", int'(grp_en), 4'b0011);
                25: chk("ramp_t25", int'(grp_en), 4'b1011);
                32: chk("ramp_t32_state", int'(state_dbg), int'(RAMP_UP));
                33: chk("act_on_t33", int'(state_dbg), int'(ACT_ON));
                default: ;
            endcase
        end
        do_stop();
        idle_wait();

        // Stop at cycle 20 of the same ramp.
        start_run(4'b1011, MODE_CONT, 0, 0);
        for (int t = 1; t <= 19; t++) cycle();
        do_stop();
        cycle();
        chk("down_t21", int'(grp_en), 4'b0001);
        for (int t = 22; t <= 29; t++) cycle();
        chk("down_t29", int'(grp_en), 4'b0000);
        chk("down_t29_busy", int'(busy), 1);
        cycle();
        chk("down_t30_busy", int'(busy), 0);
        idle_wait();

        // Burst 5/3 and degenerate burst with off=0.
        start_run(4'hF, MODE_BURST, 5, 3);
        for (int t = 1; t <= 33 + 5 * 8; t++) cycle();
        do_stop();
        idle_wait();
        start_run(4'hF, MODE_BURST, 5, 0);
        for (int t = 1; t <= 60; t++) cycle();
        chk("off0_en", int'(grp_en), 4'hF);
        do_stop();
        idle_wait();

        // Fail on an enabled group and on a masked-off group.
        grp_pass = 4'hF;
        start_run(4'b1011, MODE_CONT, 0, 0);
        for (int t = 1; t <= 36; t++) cycle();
        chk("pass_before_fail", int'(pass_out), 1);
        grp_fail = 4'b0110;
        for (int i = 0; i < 3; i++) cycle();
        grp_fail = '0;
        cycle();
        cycle();
        chk("sticky_0010", int'(fail_sticky), 4'b0010);
        chk("err_3", int'(err_cnt), 3);
        chk("pass_after_fail", int'(pass_out), 0);
        do_stop();
        idle_wait();
        start_run(4'b1011, MODE_CONT, 0, 0);
        chk("sticky_cleared", int'(fail_sticky), 0);
        chk("err_cleared", int'(err_cnt), 0);

        // Saturation of the 4-bit error counter.
        for (int t = 1; t <= 34; t++) cycle();
        grp_fail = 4'b0001;
        for (int i = 0; i < 40; i++) cycle();
        grp_fail = '0;
        cycle();
        chk("err_sat", int'(err_cnt), 15);
        do_stop();
        idle_wait();

        // start and stop together in IDLE.
        start = 1'b1;
        stop  = 1'b1;
        cycle();
        start = 1'b0;
        stop  = 1'b0;
        cycle();
        chk("start_stop_idle", int'(busy), 0);

        // Randomised runs.
        rand_io = 1'b1;
        for (int r = 0; r < 12; r++) begin
            start_run(N'($urandom), 1'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
            for (int t = 0; t < int'($urandom_range(0, 80)); t++) cycle();
            do_stop();
            idle_wait();
        end
        rand_io  = 1'b0;
        grp_pass = '0;
        grp_fail = '0;

        // Asynchronous reset in the middle of ACT_ON.
        start_run(4'b1011, MODE_CONT, 0, 0);
        for (int t = 1; t <= 40; t++) cycle();
        @(negedge dut_clk);
        #1 reset_n = 1'b0;
        #1;
        chk("async_rst_en", int'(grp_en), 0);
        chk("async_rst_busy", int'(busy), 0);
        m_run    = 1'b0;
        e_state  = IDLE;
        e_en     = '0;
        e_sticky = '0;
        e_err    = '0;
        e_pass   = 1'b0;
        @(posedge dut_clk);
        #1 reset_n = 1'b1;
        start_run(4'b0101, MODE_BURST, 2, 2);
        for (int t = 1; t <= 50; t++) cycle();
        do_stop();
        idle_wait();

        @(negedge dut_clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/power_noise_sequencer.md
# power_noise_sequencer

Run-time controller for the power-noise test design that replaces free-running, always-on load groups with sequenced, gated activity. It enables up to NUM_GROUPS load groups (BRAM, DSP and LUT-register banks) in a staged ramp to bound di/dt. It can then hold them on continuously or square-wave them in burst mode to inject programmable load steps. Per-group pass/fail is aggregated into sticky flags and a saturating error counter for the top-level status output.

## Interface
Parameters:
- NUM_GROUPS, 4, number of independently gated load groups (1..16)
- RAMP_STEP_CYC, 256, dwell cycles per group index during ramp-up/ramp-down (>=1)
- BURST_W, 16, width of on/off period counters
- ERR_CNT_W, 16, width of error counter

Ports:
- dut_clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to begin a run; ignored unless IDLE
- stop  in  1  single-cycle request to end a run; ignored in IDLE
- mode  in  1  0 = continuous, 1 = burst; latched on accepted start
- group_mask  in  NUM_GROUPS  groups participating; latched on start
- on_cycles  in  BURST_W  burst ON length; latched on start
- off_cycles  in  BURST_W  burst OFF length; latched on start
- grp_pass  in  NUM_GROUPS  per-group pass from load blocks
- grp_fail  in  NUM_GROUPS  per-group fail from load blocks
- grp_en  out  NUM_GROUPS  registered per-group activity enable
- busy  out  1  high whenever state != IDLE
- pass_out  out  1  aggregated pass
- fail_out  out  1  OR of fail_sticky
- fail_sticky  out  NUM_GROUPS  per-group latched fail
- err_cnt  out  ERR_CNT_W  saturating count of failing cycles

## Operation
- States: IDLE, RAMP_UP, ACT_ON, ACT_OFF, RAMP_DOWN.
- IDLE:
  - accepted start latches the config, clears fail_sticky and err_cnt, index = 0, and goes to RAMP_UP.
- RAMP_UP:
  - each index k = 0..NUM_GROUPS-1 dwells exactly RAMP_STEP_CYC cycles, whether masked or not.
  - at dwell entry, grp_en[k] is set if mask[k].
  - after index NUM_GROUPS-1 dwell, go to ACT_ON.
- ACT_ON:
  - grp_en = mask.
  - mode 0: stay until stop.
  - mode 1: after on_cycles cycles (0 treated as 1), go to ACT_OFF; if off_cycles = 0, stay in ACT_ON (degenerates to continuous).
- ACT_OFF:
  - grp_en = 0; after off_cycles cycles, return to ACT_ON.
  - this ON/OFF step is deliberately abrupt.
- stop from RAMP_UP/ACT_ON → RAMP_DOWN.
- RAMP_DOWN:
  - clear the highest set grp_en bit, dwell RAMP_STEP_CYC, repeat.
  - when grp_en = 0, go to IDLE next cycle.
- stop from ACT_OFF → IDLE directly, since nothing is enabled.
- start and stop in the same cycle: stop wins; in IDLE both are ignored.
- Status:
  - fail_sticky[i] sets when grp_fail[i] & grp_en[i]; it holds until the next accepted start.
  - err_cnt += 1 on any cycle where (grp_fail & grp_en) != 0; it saturates at all-ones.
  - pass_out = (state == ACT_ON) & ((grp_pass & mask) == mask) & ~fail_out, registered.
  - fail on a disabled group is ignored.
- reset_n low, at any time: state IDLE, all outputs 0, latched config 0.

## Timing
- start sampled at edge T0 → busy = 1 and grp_en[0] = mask[0] after edge T0+1.
- grp_en[k] is valid from edge T0+1+k·RAMP_STEP_CYC.
- ACT_ON is entered at T0+1+NUM_GROUPS·RAMP_STEP_CYC.
- Burst period = on_cycles+off_cycles cycles exactly; grp_en follows the state with no extra latency.
- stop at edge S → the first grp_en bit clears after S+1.
- Status outputs lag their inputs by 1 cycle (registered).
- Counters are BURST_W-bit down-counters loaded on state entry.
- Ramp counter width is $clog2(RAMP_STEP_CYC+1).

## Structure
- Package power_noise_pkg holds:
  - the state enum (state_t: IDLE, RAMP_UP, ACT_ON, ACT_OFF, RAMP_DOWN);
  - mode constants MODE_CONT = 0, MODE_BURST = 1.
- Sub-module power_noise_status holds fail_sticky, err_cnt saturation and pass_out aggregation.
  - inputs: grp_pass, grp_fail, grp_en, mask, clear, act_on.
  - the FSM and counters stay in the parent.

## Test plan
- NUM_GROUPS=4, RAMP_STEP_CYC=8, mask=4'b1011, mode 0, start at cycle 0:
  - grp_en goes 0001@1, 0011@9, 0011@17, 1011@25;
  - ACT_ON from cycle 33; busy = 1.
- Burst mode, on=5, off=3, mask=4'hF, after ramp:
  - grp_en square wave of 5 cycles 4'hF and 3 cycles 0, repeated for ≥4 periods;
  - off=0 keeps 4'hF constant.
- Stop at cycle 20 of the first test:
  - bits clear highest-first: 0001@21, 0000@29;
  - IDLE@30, busy = 0.
- grp_fail[1] pulsed 3 cycles while enabled, and grp_fail[2] while masked off:
  - fail_sticky = 4'b0010, err_cnt = 3, pass_out = 0;
  - next start clears both.
- ERR_CNT_W=4, grp_fail[0] held 40 cycles in ACT_ON:
  - err_cnt saturates at 15.
- Edge cases:
  - start+stop in the same cycle from IDLE → stays IDLE;
  - reset_n low mid-ACT_ON → grp_en = 0 asynchronously and busy = 0.
